// File: rtl/lsu_issue_queue.sv
// In-order load/store/AMO issue queue: compacts up to ENQ_W lanes per
// bundle into a ring buffer and dispatches one head entry per cycle.
// Optional feature: define LSUQ_PERF_CNT_EN to add stall/full counters.
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   i_flush_1          branch-mispredict flush (sync)
//   i_drive_1/o_free_1 upstream bundle handshake
//   i_laneValid_4      per-lane valid, lane 0 oldest
//   i_inst_292         ENQ_W packed instruction words
//   o_drive_1/i_free_1 LSU head handshake
//   o_inst_73          head instruction (0 when empty)
//   o_isStore_1        head is a store
//   o_isAmo_1          head is an AMO
//   o_count_5          occupancy
//   o_empty_1          queue empty
//   o_full_1           queue full
//   o_badOp_1          sticky illegal-opcode flag
//   o_stallCnt_16      (perf) head-stall cycles
//   o_fullCnt_16       (perf) refused-bundle cycles
module lsu_issue_queue #(
   parameter int DEPTH  = 16,
   parameter int ENQ_W  = 4,
   parameter int INST_W = 73
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_flush_1,
   input  logic                      i_drive_1,
   output logic                      o_free_1,
   input  logic [ENQ_W-1:0]          i_laneValid_4,
   input  logic [ENQ_W*INST_W-1:0]   i_inst_292,
   output logic                      o_drive_1,
   input  logic                      i_free_1,
   output logic [INST_W-1:0]         o_inst_73,
   output logic                      o_isStore_1,
   output logic                      o_isAmo_1,
   output logic [$clog2(DEPTH):0]    o_count_5,
   output logic                      o_empty_1,
   output logic                      o_full_1,
`ifdef LSUQ_PERF_CNT_EN
   output logic [15:0]               o_stallCnt_16,
   output logic [15:0]               o_fullCnt_16,
`endif
   output logic                      o_badOp_1
);

   localparam int PW = $clog2(DEPTH) + 1;
   localparam int IW = PW - 1;

   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_AMO = 7'b0101111;

   localparam logic [PW-1:0] FREE_MAX = PW'(DEPTH - ENQ_W);

   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [PW-1:0]     count_q, count_d;
   logic              badop_q, badop_d;

   logic [INST_W-1:0] mem_q [DEPTH];

   logic [INST_W-1:0] lane_inst [ENQ_W];
   logic [6:0]        lane_op   [ENQ_W];
   logic [ENQ_W-1:0]  legal;
   logic [ENQ_W-1:0]  bad;
   logic [PW-1:0]     off       [ENQ_W];
   logic [IW-1:0]     widx      [ENQ_W];
   logic [PW-1:0]     n_enq;
   logic [PW-1:0]     n_add;
   logic              enq_fire;
   logic              deq_fire;
   logic [INST_W-1:0] head_inst;

   // Lane decode: split words, classify opcodes.
   always_comb begin
      for (int k = 0; k < ENQ_W; k++) begin
         lane_inst[k] = i_inst_292[k*INST_W +: INST_W];
         lane_op[k]   = lane_inst[k][6:0];
         legal[k]     = i_laneValid_4[k] &
                        ((lane_op[k] == OP_LD) |
                         (lane_op[k] == OP_ST) |
                         (lane_op[k] == OP_AMO));
         bad[k]       = i_laneValid_4[k] & ~legal[k];
      end
   end

   // Compaction: each legal lane lands at tail plus the
   // number of legal lanes older than it.
   always_comb begin
      logic [PW-1:0] acc;
      acc = '0;
      for (int k = 0; k < ENQ_W; k++) begin
         off[k]  = acc;
         widx[k] = tail_q[IW-1:0] + off[k][IW-1:0];
         acc     = acc + PW'(legal[k]);
      end
      n_enq = acc;
   end

   // Free depends on registered count only, so the whole
   // bundle is accepted or refused without a comb loop.
   assign o_free_1  = (count_q <= FREE_MAX);
   assign o_empty_1 = (head_q == tail_q);
   assign o_full_1  = (head_q[IW-1:0] == tail_q[IW-1:0]) &
                      (head_q[IW] != tail_q[IW]);
   assign o_drive_1 = ~o_empty_1;
   assign o_count_5 = count_q;
   assign o_badOp_1 = badop_q;

   assign enq_fire = i_drive_1 & o_free_1 & ~i_flush_1;
   assign deq_fire = o_drive_1 & i_free_1 & ~i_flush_1;
   assign n_add    = enq_fire ? n_enq : '0;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      badop_d = badop_q;
      if (i_flush_1) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         badop_d = 1'b0;
      end else begin
         if (enq_fire) begin
            tail_d  = tail_q + n_enq;
            badop_d = badop_q | (|bad);
         end
         if (deq_fire) begin
            head_d = head_q + PW'(1);
         end
         count_d = count_q + n_add - PW'(deq_fire);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         badop_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         badop_q <= badop_d;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < ENQ_W; k++) begin
         if (enq_fire && legal[k]) begin
            mem_q[widx[k]] <= lane_inst[k];
         end
      end
   end

   assign head_inst   = mem_q[head_q[IW-1:0]];
   assign o_inst_73   = o_drive_1 ? head_inst : '0;
   assign o_isStore_1 = o_drive_1 & (head_inst[6:0] == OP_ST);
   assign o_isAmo_1   = o_drive_1 & (head_inst[6:0] == OP_AMO);

`ifdef LSUQ_PERF_CNT_EN
   logic [15:0] stall_q;
   logic [15:0] fullc_q;

   // Saturating counters; flush does not clear them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_q <= '0;
         fullc_q <= '0;
      end else begin
         if (o_drive_1 && !i_free_1 && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
         end
         if (i_drive_1 && !o_free_1 && fullc_q != 16'hFFFF) begin
            fullc_q <= fullc_q + 16'd1;
         end
      end
   end

   assign o_stallCnt_16 = stall_q;
   assign o_fullCnt_16  = fullc_q;
`endif

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed self-checking bench for lsu_issue_queue.
// Perf-counter scenario runs only when LSUQ_PERF_CNT_EN is defined.
module tb_lsu_issue_queue;

   localparam int DEPTH  = 16;
   localparam int ENQ_W  = 4;
   localparam int INST_W = 73;

   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] ST  = 7'b0100011;
   localparam logic [6:0] AMO = 7'b0101111;
   localparam logic [6:0] ALU = 7'b0110011;

   logic                    clk;
   logic                    rstn;
   logic                    i_flush_1;
   logic                    i_drive_1;
   logic                    o_free_1;
   logic [ENQ_W-1:0]        i_laneValid_4;
   logic [ENQ_W*INST_W-1:0] i_inst_292;
   logic                    o_drive_1;
   logic                    i_free_1;
   logic [INST_W-1:0]       o_inst_73;
   logic                    o_isStore_1;
   logic                    o_isAmo_1;
   logic [4:0]              o_count_5;
   logic                    o_empty_1;
   logic                    o_full_1;
   logic                    o_badOp_1;
`ifdef LSUQ_PERF_CNT_EN
   logic [15:0]             o_stallCnt_16;
   logic [15:0]             o_fullCnt_16;
`endif

   int checks;
   int failures;

   lsu_issue_queue #(
      .DEPTH (DEPTH),
      .ENQ_W (ENQ_W),
      .INST_W(INST_W)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_flush_1    (i_flush_1),
      .i_drive_1    (i_drive_1),
      .o_free_1     (o_free_1),
      .i_laneValid_4(i_laneValid_4),
      .i_inst_292   (i_inst_292),
      .o_drive_1    (o_drive_1),
      .i_free_1     (i_free_1),
      .o_inst_73    (o_inst_73),
      .o_isStore_1  (o_isStore_1),
      .o_isAmo_1    (o_isAmo_1),
      .o_count_5    (o_count_5),
      .o_empty_1    (o_empty_1),
      .o_full_1     (o_full_1),
`ifdef LSUQ_PERF_CNT_EN
      .o_stallCnt_16(o_stallCnt_16),
      .o_fullCnt_16 (o_fullCnt_16),
`endif
      .o_badOp_1    (o_badOp_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [INST_W-1:0] mk(input logic [6:0] op,
                                            input int tag);
      return {66'(tag), op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int k, input logic [INST_W-1:0] w);
      i_inst_292[k*INST_W +: INST_W] = w;
   endtask

   task automatic load_bundle(input int tag0);
      for (int k = 0; k < ENQ_W; k++) set_lane(k, mk(LD, tag0 + k));
   endtask

   task automatic do_flush();
      i_flush_1 = 1'b1;
      tick();
      i_flush_1 = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (o_count_5 !== 5'd0 || o_empty_1 !== 1'b1 ||
          o_free_1 !== 1'b1 || o_drive_1 !== 1'b0 ||
          o_full_1 !== 1'b0 || o_badOp_1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags cnt=%0d e=%b f=%b d=%b full=%b bad=%b exp 0 1 1 0 0 0",
                  o_count_5, o_empty_1, o_free_1, o_drive_1, o_full_1, o_badOp_1);
      end
      checks++;
      if (o_inst_73 !== '0 || o_isStore_1 !== 1'b0 || o_isAmo_1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_head inst=%h st=%b amo=%b exp 0 0 0",
                  o_inst_73, o_isStore_1, o_isAmo_1);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      i_drive_1     = 1'b1;
      i_laneValid_4 = 4'b1011;
      set_lane(0, mk(LD, 1));
      set_lane(1, mk(ST, 2));
      set_lane(2, mk(ALU, 3));
      set_lane(3, mk(AMO, 4));
      i_free_1 = 1'b0;
      tick();
      i_drive_1 = 1'b0;
      i_laneValid_4 = '0;
      checks++;
      if (o_count_5 !== 5'd3) begin
         failures++;
         $display("FAIL basic_count got=%0d exp=3", o_count_5);
      end
      checks++;
      if (o_inst_73 !== mk(LD, 1) || o_isStore_1 !== 1'b0 || o_drive_1 !== 1'b1) begin
         failures++;
         $display("FAIL basic_head inst=%h st=%b d=%b exp=%h 0 1",
                  o_inst_73, o_isStore_1, o_drive_1, mk(LD, 1));
      end
      i_free_1 = 1'b1;
      tick();
      checks++;
      if (o_inst_73 !== mk(ST, 2) || o_isStore_1 !== 1'b1) begin
         failures++;
         $display("FAIL basic_store inst=%h st=%b exp=%h 1",
                  o_inst_73, o_isStore_1, mk(ST, 2));
      end
      tick();
      checks++;
      if (o_inst_73 !== mk(AMO, 4) || o_isAmo_1 !== 1'b1 || o_isStore_1 !== 1'b0) begin
         failures++;
         $display("FAIL basic_amo inst=%h amo=%b st=%b exp=%h 1 0",
                  o_inst_73, o_isAmo_1, o_isStore_1, mk(AMO, 4));
      end
      tick();
      i_free_1 = 1'b0;
      checks++;
      if (o_empty_1 !== 1'b1 || o_inst_73 !== '0 || o_drive_1 !== 1'b0) begin
         failures++;
         $display("FAIL basic_drain e=%b inst=%h d=%b exp 1 0 0",
                  o_empty_1, o_inst_73, o_drive_1);
      end
      checks++;
      if (o_badOp_1 !== 1'b0) begin
         failures++;
         $display("FAIL basic_badop got=%b exp=0", o_badOp_1);
      end
   endtask

   task automatic test_fill_wrap();
      do_flush();
      i_laneValid_4 = 4'b1111;
      i_drive_1     = 1'b1;
      for (int b = 0; b < 4; b++) begin
         load_bundle(b * 4);
         tick();
      end
      i_drive_1 = 1'b0;
      checks++;
      if (o_count_5 !== 5'd16 || o_full_1 !== 1'b1 || o_free_1 !== 1'b0) begin
         failures++;
         $display("FAIL fill_full cnt=%0d full=%b free=%b exp 16 1 0",
                  o_count_5, o_full_1, o_free_1);
      end
      load_bundle(16);
      i_drive_1 = 1'b1;
      tick();
      checks++;
      if (o_count_5 !== 5'd16) begin
         failures++;
         $display("FAIL fill_refuse cnt=%0d exp=16", o_count_5);
      end
      i_free_1 = 1'b1;
      repeat (4) tick();
      i_free_1 = 1'b0;
      checks++;
      if (o_count_5 !== 5'd12 || o_free_1 !== 1'b1 || o_inst_73 !== mk(LD, 4)) begin
         failures++;
         $display("FAIL fill_reopen cnt=%0d free=%b inst=%h exp 12 1 %h",
                  o_count_5, o_free_1, o_inst_73, mk(LD, 4));
      end
      tick();
      i_drive_1 = 1'b0;
      i_laneValid_4 = '0;
      checks++;
      if (o_count_5 !== 5'd16 || o_full_1 !== 1'b1) begin
         failures++;
         $display("FAIL fill_held cnt=%0d full=%b exp 16 1", o_count_5, o_full_1);
      end
      i_free_1 = 1'b1;
      for (int i = 4; i < 20; i++) begin
         checks++;
         if (o_inst_73 !== mk(LD, i)) begin
            failures++;
            $display("FAIL wrap_order[%0d] got=%h exp=%h", i, o_inst_73, mk(LD, i));
         end
         tick();
      end
      i_free_1 = 1'b0;
      checks++;
      if (o_empty_1 !== 1'b1) begin
         failures++;
         $display("FAIL wrap_empty got=%b exp=1", o_empty_1);
      end
   endtask

   task automatic test_badop();
      do_flush();
      i_drive_1     = 1'b1;
      i_laneValid_4 = 4'b0011;
      set_lane(0, mk(LD, 50));
      set_lane(1, mk(ALU, 51));
      tick();
      i_drive_1 = 1'b0;
      i_laneValid_4 = '0;
      checks++;
      if (o_count_5 !== 5'd1 || o_badOp_1 !== 1'b1 || o_inst_73 !== mk(LD, 50)) begin
         failures++;
         $display("FAIL badop_set cnt=%0d bad=%b inst=%h exp 1 1 %h",
                  o_count_5, o_badOp_1, o_inst_73, mk(LD, 50));
      end
      i_free_1 = 1'b1;
      tick();
      i_free_1 = 1'b0;
      repeat (3) tick();
      checks++;
      if (o_badOp_1 !== 1'b1 || o_empty_1 !== 1'b1) begin
         failures++;
         $display("FAIL badop_sticky bad=%b e=%b exp 1 1", o_badOp_1, o_empty_1);
      end
      do_flush();
      checks++;
      if (o_badOp_1 !== 1'b0) begin
         failures++;
         $display("FAIL badop_flush got=%b exp=0", o_badOp_1);
      end
   endtask

   task automatic test_back_to_back();
      do_flush();
      i_drive_1     = 1'b1;
      i_laneValid_4 = 4'b1111;
      load_bundle(60);
      tick();
      i_laneValid_4 = 4'b0001;
      set_lane(0, mk(LD, 64));
      tick();
      i_drive_1 = 1'b0;
      checks++;
      if (o_count_5 !== 5'd5) begin
         failures++;
         $display("FAIL b2b_setup cnt=%0d exp=5", o_count_5);
      end
      i_drive_1     = 1'b1;
      i_laneValid_4 = 4'b0011;
      set_lane(0, mk(LD, 65));
      set_lane(1, mk(LD, 66));
      i_free_1 = 1'b1;
      tick();
      checks++;
      if (o_count_5 !== 5'd6 || o_inst_73 !== mk(LD, 61)) begin
         failures++;
         $display("FAIL b2b_simul cnt=%0d inst=%h exp 6 %h",
                  o_count_5, o_inst_73, mk(LD, 61));
      end
      i_flush_1 = 1'b1;
      tick();
      i_flush_1 = 1'b0;
      i_drive_1 = 1'b0;
      i_free_1  = 1'b0;
      i_laneValid_4 = '0;
      checks++;
      if (o_count_5 !== 5'd0 || o_drive_1 !== 1'b0 || o_empty_1 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_flush cnt=%0d d=%b e=%b exp 0 0 1",
                  o_count_5, o_drive_1, o_empty_1);
      end
   endtask

   task automatic test_async_reset();
      i_drive_1     = 1'b1;
      i_laneValid_4 = 4'b1111;
      load_bundle(100);
      set_lane(3, mk(ALU, 103));
      tick();
      load_bundle(104);
      tick();
      load_bundle(108);
      tick();
      i_drive_1 = 1'b0;
      i_laneValid_4 = '0;
      i_free_1 = 1'b1;
      repeat (2) tick();
      i_free_1 = 1'b0;
      checks++;
      if (o_count_5 !== 5'd9 || o_badOp_1 !== 1'b1) begin
         failures++;
         $display("FAIL arst_setup cnt=%0d bad=%b exp 9 1", o_count_5, o_badOp_1);
      end
      #3;
      rstn = 1'b0;
      #1;
      checks++;
      if (o_count_5 !== 5'd0 || o_empty_1 !== 1'b1 || o_drive_1 !== 1'b0 ||
          o_inst_73 !== '0 || o_badOp_1 !== 1'b0 || o_free_1 !== 1'b1) begin
         failures++;
         $display("FAIL arst_now cnt=%0d e=%b d=%b inst=%h bad=%b free=%b exp 0 1 0 0 0 1",
                  o_count_5, o_empty_1, o_drive_1, o_inst_73, o_badOp_1, o_free_1);
      end
      #2;
      rstn = 1'b1;
      i_drive_1     = 1'b1;
      i_laneValid_4 = 4'b0001;
      set_lane(0, mk(ST, 200));
      tick();
      i_drive_1 = 1'b0;
      i_laneValid_4 = '0;
      checks++;
      if (o_count_5 !== 5'd1 || o_inst_73 !== mk(ST, 200) || o_isStore_1 !== 1'b1) begin
         failures++;
         $display("FAIL arst_index0 cnt=%0d inst=%h st=%b exp 1 %h 1",
                  o_count_5, o_inst_73, o_isStore_1, mk(ST, 200));
      end
   endtask

`ifdef LSUQ_PERF_CNT_EN
   task automatic test_perf();
      i_free_1 = 1'b0;
      repeat (70000) tick();
      checks++;
      if (o_stallCnt_16 !== 16'hFFFF) begin
         failures++;
         $display("FAIL perf_stall_sat got=%h exp=ffff", o_stallCnt_16);
      end
      checks++;
      if (o_fullCnt_16 !== 16'h0000) begin
         failures++;
         $display("FAIL perf_full got=%h exp=0000", o_fullCnt_16);
      end
   endtask
`endif

   initial begin
      checks        = 0;
      failures      = 0;
      rstn          = 1'b0;
      i_flush_1     = 1'b0;
      i_drive_1     = 1'b0;
      i_free_1      = 1'b0;
      i_laneValid_4 = '0;
      i_inst_292    = '0;
      test_reset();
      test_basic();
      test_fill_wrap();
      test_badop();
      test_back_to_back();
      test_async_reset();
`ifdef LSUQ_PERF_CNT_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_issue_queue.md
Name: lsu_issue_queue

Overview:
- In-order load/store/AMO issue queue directly downstream of the Issue stage.
- Each cycle it accepts a bundle of up to ENQ_W classified memory instructions (73-bit instruction words, opcode in bits [6:0]) and compacts them into a ring buffer.
- Dispatches one entry per cycle to the LSU over a drive/free handshake.
- Cleared by a branch-mispredict flush.

Parameters:
- DEPTH, 16, queue entries (power of two, >= ENQ_W).
- ENQ_W, 4, enqueue lanes per bundle.
- INST_W, 73, instruction word width.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- i_flush_1  input  1  branch-mispredict flush, synchronous
- i_drive_1  input  1  upstream bundle valid
- o_free_1  output  1  queue can accept a full bundle (free entries >= ENQ_W)
- i_laneValid_4  input  ENQ_W  per-lane valid; lane 0 is oldest
- i_inst_292  input  ENQ_W*INST_W  lane k at [k*INST_W +: INST_W]
- o_drive_1  output  1  head entry valid toward LSU
- i_free_1  input  1  LSU accepts head this cycle
- o_inst_73  output  INST_W  head instruction; 0 when empty
- o_isStore_1  output  1  head opcode is 0100011, gated by o_drive_1
- o_isAmo_1  output  1  head opcode is 0101111, gated by o_drive_1
- o_count_5  output  $clog2(DEPTH)+1  occupancy
- o_empty_1  output  1  count == 0
- o_full_1  output  1  count == DEPTH
- o_badOp_1  output  1  sticky: a valid lane carried a non-LSU opcode

Behaviour:
- Reset (rstn low, asynchronous):
  - Head/tail pointers and count go to 0; o_badOp_1 goes to 0.
  - o_free_1=1, o_empty_1=1; o_drive_1, o_full_1, o_isStore_1, o_isAmo_1 = 0; o_inst_73 = 0.
  - Storage contents are not reset.
- Pointers: head and tail are $clog2(DEPTH)+1 bits binary; the MSB is the wrap bit. Index = low bits.
  - Empty: head == tail.
  - Full: low bits equal and wrap bits differ.
- Legal opcodes: 0000011 (load), 0100011 (store), 0101111 (AMO).
  - A valid lane with any other opcode is dropped and not enqueued; it sets o_badOp_1.
- Enqueue fires when i_drive_1 & o_free_1 & !i_flush_1.
  - Legal valid lanes are written in ascending lane order to tail, tail+1, ... with wrap-around.
  - tail advances by the number of legal lanes (0..ENQ_W).
  - If i_drive_1 is high while o_free_1 is low, the whole bundle is refused, with no partial acceptance. Upstream holds the bundle.
- o_free_1 depends only on registered count (no combinational path from i_drive_1 or i_laneValid_4).
- Dequeue fires when o_drive_1 & i_free_1 & !i_flush_1. head advances by 1.
  - o_drive_1 = !o_empty_1.
  - o_inst_73 is a combinational read of mem[head]; it is stable while o_drive_1 & !i_free_1.
- Latency: an entry enqueued at edge t is visible at o_inst_73 from cycle t+1. No same-cycle bypass.
- Simultaneous enqueue of n lanes and dequeue: count_next = count + n - 1.
  - Dequeue from a full queue with a refused enqueue is allowed; o_free_1 rises the following cycle only if DEPTH-count+1 >= ENQ_W.
- Flush: on the next edge head=tail=0, count=0, o_badOp_1=0.
  - Flush has priority over enqueue and dequeue in the same cycle; both are ignored.
- Reset asserted mid-operation aborts all state immediately; no entry survives.
- o_count_5 is never allowed to exceed DEPTH; the enqueue guard guarantees it.

Optional Feature:
- Macro LSUQ_PERF_CNT_EN.
- Defined: adds two output ports, each a 16-bit saturating counter cleared by reset only (not by flush):
  - o_stallCnt_16 counts cycles with o_drive_1 & !i_free_1.
  - o_fullCnt_16 counts cycles with i_drive_1 & !o_free_1.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then bundle with laneValid=4'b1011 carrying load, store, AMO, with i_free_1=0 -> count=3, head=lane0 load, o_isStore_1=0; pull i_free_1 for 3 cycles -> load, store, AMO in order, then o_empty_1=1, o_inst_73=0.
- Fill with 4 full bundles (count=16) -> o_full_1=1, o_free_1=0; a 5th bundle is refused and held; dequeue 4 -> o_free_1=1 next cycle, held bundle accepted, tail wraps, order preserved across index 15->0.
- Lane opcode 0110011 among valid lanes 4'b0011 -> only lane 0 enqueued, count=1, o_badOp_1=1 and stays 1 until flush.
- count=5, same-cycle enqueue of 2 and dequeue -> count=6 next cycle; same cycle plus i_flush_1=1 -> count=0, o_drive_1=0.
- Assert rstn low asynchronously between edges with count=9 -> outputs go to reset values immediately; the first bundle after release lands at index 0.
- With LSUQ_PERF_CNT_EN: hold head with i_free_1=0 for 70000 cycles -> o_stallCnt_16 saturates at 16'hFFFF.
